// File: rtl/approx_error_monitor.sv
// rtl/approx_error_monitor.sv - windowed error metrics between approximate and exact FIR output streams
module approx_error_monitor #(
    parameter int WIDTH    = 16,
    parameter int LOG2_WIN = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          approx_in,
    input  logic [WIDTH-1:0]          exact_in,
    output logic                      busy,
    output logic                      done,
    output logic [LOG2_WIN:0]         err_count,
    output logic [WIDTH-1:0]          max_abs_err,
    output logic [WIDTH+LOG2_WIN-1:0] sum_abs_err,
    output logic [WIDTH-1:0]          mean_abs_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [LOG2_WIN-1:0]       cnt_q;
    logic                      s1_valid_q;
    logic                      s1_nz_q;
    logic [WIDTH-1:0]          s1_abs_q;
    logic [LOG2_WIN:0]         err_count_q;
    logic [WIDTH-1:0]          max_abs_q;
    logic [WIDTH+LOG2_WIN-1:0] sum_abs_q;

    logic             accept;
    logic             last_sample;
    logic             restart;
    logic [WIDTH-1:0] abs_d;

    // The counter only ranges 0..2^LOG2_WIN-1, so all-ones marks the final sample of the window.
    assign accept      = (state_q == S_RUN) && in_valid;
    assign last_sample = accept && (cnt_q == {LOG2_WIN{1'b1}});
    assign restart     = start && !clear && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Unsigned magnitude of the difference; ordering the operands is equivalent to a signed
    // WIDTH+1 subtraction followed by abs, and the result always fits in WIDTH bits.
    assign abs_d = (approx_in >= exact_in) ? (approx_in - exact_in) : (exact_in - approx_in);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything, start only matters in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_RUN;
                S_RUN:   if (last_sample) state_d = S_FLUSH;
                S_FLUSH: state_d = S_DONE;
                S_DONE:  if (start) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN, S_FLUSH: busy = 1'b1;
            S_DONE:         done = 1'b1;
            default:        ;
        endcase
    end

    // Accepted-sample counter; wraps to zero naturally on the last sample of a window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || restart) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Stage 1: capture absolute difference and nonzero flag of each accepted pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_nz_q    <= 1'b0;
            s1_abs_q   <= '0;
        end else if (clear || restart) begin
            s1_valid_q <= 1'b0;
            s1_nz_q    <= 1'b0;
            s1_abs_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_nz_q  <= (abs_d != '0);
                s1_abs_q <= abs_d;
            end
        end
    end

    // Stage 2: fold the stage-1 result into the running metrics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
            max_abs_q   <= '0;
            sum_abs_q   <= '0;
        end else if (clear || restart) begin
            err_count_q <= '0;
            max_abs_q   <= '0;
            sum_abs_q   <= '0;
        end else if (s1_valid_q) begin
            err_count_q <= err_count_q + {{LOG2_WIN{1'b0}}, s1_nz_q};
            sum_abs_q   <= sum_abs_q + {{LOG2_WIN{1'b0}}, s1_abs_q};
            if (s1_abs_q > max_abs_q) begin
                max_abs_q <= s1_abs_q;
            end
        end
    end

    assign err_count    = err_count_q;
    assign max_abs_err  = max_abs_q;
    assign sum_abs_err  = sum_abs_q;
    assign mean_abs_err = sum_abs_q[WIDTH+LOG2_WIN-1:LOG2_WIN];

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb/tb_approx_error_monitor.sv - directed self-checking bench for approx_error_monitor
module tb_approx_error_monitor;

    localparam int WIDTH    = 16;
    localparam int LOG2_WIN = 2;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic                      clear;
    logic                      in_valid;
    logic [WIDTH-1:0]          approx_in;
    logic [WIDTH-1:0]          exact_in;
    logic                      busy;
    logic                      done;
    logic [LOG2_WIN:0]         err_count;
    logic [WIDTH-1:0]          max_abs_err;
    logic [WIDTH+LOG2_WIN-1:0] sum_abs_err;
    logic [WIDTH-1:0]          mean_abs_err;

    int checks;
    int errors;

    approx_error_monitor #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .in_valid     (in_valid),
        .approx_in    (approx_in),
        .exact_in     (exact_in),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .max_abs_err  (max_abs_err),
        .sum_abs_err  (sum_abs_err),
        .mean_abs_err (mean_abs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic v, input int a, input int e);
        in_valid  = v;
        approx_in = a[WIDTH-1:0];
        exact_in  = e[WIDTH-1:0];
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0d exp=0", done); end
        tick();
        checks++; if (sum_abs_err !== 18'd0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", sum_abs_err); end
        checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", err_count); end
        checks++; if (max_abs_err !== 16'd0) begin errors++; $display("FAIL reset_max got=%0d exp=0", max_abs_err); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mixed_errors();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mixed_busy_start got=%0d exp=1", busy); end
        send(1'b1, 100, 103);
        send(1'b1, 50, 50);
        send(1'b1, 200, 190);
        send(1'b1, 0, 65535);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mixed_flush got done=%0d busy=%0d exp done=0 busy=1", done, busy); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mixed_done got done=%0d busy=%0d exp done=1 busy=0", done, busy); end
        checks++; if (err_count !== 3'd3) begin errors++; $display("FAIL mixed_count got=%0d exp=3", err_count); end
        checks++; if (max_abs_err !== 16'd65535) begin errors++; $display("FAIL mixed_max got=%0d exp=65535", max_abs_err); end
        checks++; if (sum_abs_err !== 18'd65548) begin errors++; $display("FAIL mixed_sum got=%0d exp=65548", sum_abs_err); end
        checks++; if (mean_abs_err !== 16'd16387) begin errors++; $display("FAIL mixed_mean got=%0d exp=16387", mean_abs_err); end
        send(1'b1, 7, 1000);
        send(1'b1, 9, 3);
        checks++; if (done !== 1'b1 || sum_abs_err !== 18'd65548 || err_count !== 3'd3) begin
            errors++; $display("FAIL mixed_hold got done=%0d sum=%0d count=%0d exp done=1 sum=65548 count=3", done, sum_abs_err, err_count);
        end
    endtask

    task automatic test_identical_from_done();
        pulse_start();
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_state got done=%0d busy=%0d exp done=0 busy=1", done, busy); end
        checks++; if (sum_abs_err !== 18'd0 || max_abs_err !== 16'd0 || err_count !== 3'd0) begin
            errors++; $display("FAIL restart_clear got sum=%0d max=%0d count=%0d exp 0 0 0", sum_abs_err, max_abs_err, err_count);
        end
        for (int i = 0; i < 4; i++) send(1'b1, 'h1234, 'h1234);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ident_early_done got=%0d exp=0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ident_done got=%0d exp=1", done); end
        checks++; if (err_count !== 3'd0 || max_abs_err !== 16'd0 || sum_abs_err !== 18'd0 || mean_abs_err !== 16'd0) begin
            errors++; $display("FAIL ident_metrics got count=%0d max=%0d sum=%0d mean=%0d exp all 0", err_count, max_abs_err, sum_abs_err, mean_abs_err);
        end
    endtask

    task automatic test_start_in_run();
        pulse_start();
        send(1'b1, 1, 0);
        send(1'b1, 0, 1);
        start = 1'b1;
        send(1'b1, 1, 0);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL srun_busy got=%0d exp=1", busy); end
        send(1'b1, 0, 1);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL srun_flush got busy=%0d done=%0d exp busy=1 done=0", busy, done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL srun_done got=%0d exp=1", done); end
        checks++; if (err_count !== 3'd4 || sum_abs_err !== 18'd4 || max_abs_err !== 16'd1 || mean_abs_err !== 16'd1) begin
            errors++; $display("FAIL srun_metrics got count=%0d sum=%0d max=%0d mean=%0d exp 4 4 1 1", err_count, sum_abs_err, max_abs_err, mean_abs_err);
        end
    endtask

    task automatic test_clear_with_start();
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clr_state got busy=%0d done=%0d exp 0 0", busy, done); end
        checks++; if (sum_abs_err !== 18'd0 || err_count !== 3'd0 || max_abs_err !== 16'd0) begin
            errors++; $display("FAIL clr_metrics got sum=%0d count=%0d max=%0d exp 0 0 0", sum_abs_err, err_count, max_abs_err);
        end
        send(1'b1, 3, 9);
        tick();
        checks++; if (busy !== 1'b0 || sum_abs_err !== 18'd0) begin errors++; $display("FAIL clr_idle got busy=%0d sum=%0d exp 0 0", busy, sum_abs_err); end
    endtask

    task automatic test_gapped_valid();
        int v_tab [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int a_tab [8] = '{100, 9, 50, 1, 77, 200, 65535, 0};
        int e_tab [8] = '{103, 9999, 50, 2, 0, 190, 0, 65535};
        int busy_low;
        send(1'b1, 0, 500);
        send(1'b1, 4000, 0);
        pulse_start();
        busy_low = 0;
        for (int i = 0; i < 8; i++) begin
            send(v_tab[i][0], a_tab[i], e_tab[i]);
            if (busy !== 1'b1) busy_low++;
        end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL gap_busy got low_cycles=%0d exp=0", busy_low); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL gap_done got done=%0d busy=%0d exp 1 0", done, busy); end
        checks++; if (err_count !== 3'd3 || max_abs_err !== 16'd65535 || sum_abs_err !== 18'd65548 || mean_abs_err !== 16'd16387) begin
            errors++; $display("FAIL gap_metrics got count=%0d max=%0d sum=%0d mean=%0d exp 3 65535 65548 16387", err_count, max_abs_err, sum_abs_err, mean_abs_err);
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send(1'b1, 3, 0);
        send(1'b1, 0, 3);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_state got busy=%0d done=%0d exp 0 0", busy, done); end
        checks++; if (sum_abs_err !== 18'd0 || err_count !== 3'd0 || max_abs_err !== 16'd0) begin
            errors++; $display("FAIL arst_metrics got sum=%0d count=%0d max=%0d exp 0 0 0", sum_abs_err, err_count, max_abs_err);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle got busy=%0d exp=0", busy); end
        pulse_start();
        send(1'b1, 5, 2);
        send(1'b1, 2, 5);
        send(1'b1, 7, 7);
        send(1'b1, 9, 0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL arst_done got=%0d exp=1", done); end
        checks++; if (err_count !== 3'd3 || max_abs_err !== 16'd9 || sum_abs_err !== 18'd15 || mean_abs_err !== 16'd3) begin
            errors++; $display("FAIL arst_metrics_new got count=%0d max=%0d sum=%0d mean=%0d exp 3 9 15 3", err_count, max_abs_err, sum_abs_err, mean_abs_err);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        start     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        approx_in = '0;
        exact_in  = '0;
        test_reset();
        test_mixed_errors();
        test_identical_from_done();
        test_start_in_run();
        test_clear_with_start();
        test_gapped_valid();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
